// File: rtl/cube_tile_acc_drain_if.sv
// Tile-in / row-out stream bundle for the cube accumulation buffer.
// master drives tiles and consumes rows; slave is the buffer itself.
interface cube_tile_acc_drain_if #(
  parameter int N         = 8,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+$clog2(N),
  parameter int OUT_WIDTH = 32
);
  localparam int EW = 2*ACC_WIDTH;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic                   in_valid;
  logic                   in_first;
  logic                   in_last;
  logic [N*N*EW-1:0]      in_result;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*OUT_WIDTH-1:0] out_data;
  logic [RW-1:0]          out_row;
  logic                   out_last;

  modport master (
    output in_valid, in_first, in_last, in_result, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last
  );

  modport slave (
    input  in_valid, in_first, in_last, in_result, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/cube_tile_acc_drain.sv
// Saturating K-tile accumulator behind the cube array; drains the
// finished tile one row per beat while holding off new tiles.
module cube_tile_acc_drain #(
  parameter int N         = 8,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+$clog2(N),
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cube_tile_acc_drain_if.slave bus,
  input  logic                 clr_flags,
  output logic                 sat_flag,
  output logic                 err_flag
);
  localparam int EW = 2*ACC_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int XW = ((EW > OW) ? EW : OW) + 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [XW-1:0] MAXX =
    {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] MINX =
    {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};

  // Result is {clamped, value}.
  function automatic logic [OW:0] f_clamp(
    input logic [EW-1:0] e
  );
    logic signed [XW-1:0] x;
    x = {{(XW-EW){e[EW-1]}}, e};
    if (x > MAXX) return {1'b1, MAXV};
    if (x < MINX) return {1'b1, MINV};
    return {1'b0, x[OW-1:0]};
  endfunction

  function automatic logic [OW:0] f_add(
    input logic [OW-1:0] a,
    input logic [OW-1:0] b
  );
    logic signed [OW:0] s;
    s = $signed({a[OW-1], a}) + $signed({b[OW-1], b});
    if (s[OW] != s[OW-1])
      return {1'b1, s[OW] ? MINV : MAXV};
    return {1'b0, s[OW-1:0]};
  endfunction

  typedef enum logic {
    S_ACC,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic [OW-1:0] r_buf [N][N];
  logic [RW-1:0] r_row;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_sat;
  logic          r_err;

  logic [OW:0]     w_cl   [N][N];
  logic [OW:0]     w_ad   [N][N];
  logic [OW-1:0]   w_next [N][N];
  logic            w_sat_any;
  logic [N*OW-1:0] w_data;
  logic            w_row_end;

  always_comb begin
    w_sat_any = 1'b0;
    for (int x = 0; x < N; x++) begin
      for (int z = 0; z < N; z++) begin
        w_cl[x][z] = f_clamp(
          bus.in_result[(z*N+x)*EW +: EW]);
        w_ad[x][z] = f_add(r_buf[x][z],
                           w_cl[x][z][OW-1:0]);
        if (bus.in_first) begin
          w_next[x][z] = w_cl[x][z][OW-1:0];
          w_sat_any = w_sat_any | w_cl[x][z][OW];
        end else begin
          w_next[x][z] = w_ad[x][z][OW-1:0];
          w_sat_any = w_sat_any | w_cl[x][z][OW]
                                | w_ad[x][z][OW];
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    if (r_out_valid)
      for (int z = 0; z < N; z++)
        w_data[z*OW +: OW] = r_buf[r_row][z];
  end

  assign w_row_end = (r_row == RW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_row       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_err       <= 1'b0;
      for (int x = 0; x < N; x++)
        for (int z = 0; z < N; z++)
          r_buf[x][z] <= '0;
    end else begin
      // A set event in the same cycle as clr_flags wins.
      r_err <= (bus.in_valid & ~r_in_ready)
             | (r_err & ~clr_flags);
      r_sat <= (bus.in_valid & r_in_ready & w_sat_any)
             | (r_sat & ~clr_flags);
      unique case (r_state)
        S_ACC: begin
          if (bus.in_valid) begin
            r_buf <= w_next;
            if (bus.in_last) begin
              r_state     <= S_DRAIN;
              r_row       <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (w_row_end) begin
              r_state     <= S_ACC;
              r_row       <= '0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              for (int x = 0; x < N; x++)
                for (int z = 0; z < N; z++)
                  r_buf[x][z] <= '0;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_data;
  assign bus.out_row   = r_row;
  assign bus.out_last  = r_out_valid & w_row_end;
  assign sat_flag      = r_sat;
  assign err_flag      = r_err;
endmodule

// File: doc/cube_tile_acc_drain.md
Name: cube_tile_acc_drain

Overview:
- Downstream consumer of the N×N×N cube matmul array.
- Captures the full N×N result bus when the issue pipeline flags it valid, and accumulates successive K-tiles (inner dimension > N) into a saturating OUT_WIDTH buffer.
- After the last tile, drains the matrix one row per beat over a valid/ready stream to the writeback stage.
- While draining, throttles the issue logic through in_ready.

Parameters:
- N, 8, cube dimension (rows/cols of result tile).
- WIDTH, 8, operand width feeding the cube.
- ACC_WIDTH, 2*WIDTH+$clog2(N), cube accumulator width. Each cube result element is 2*ACC_WIDTH bits signed.
- OUT_WIDTH, 32, signed width of the accumulation buffer and output elements.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  result bus valid this cycle (aligned to cube output by issue pipeline).
- in_first  in  1  with in_valid: overwrite buffer instead of adding.
- in_last  in  1  with in_valid: final K-tile; start drain.
- in_result  in  N*N*2*ACC_WIDTH  cube result. Element C[x][z] at slice (z*N+x)*2*ACC_WIDTH, signed.
- in_ready  out  1  block accepts tiles (high in ACC state).
- out_valid  out  1  row beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  N*OUT_WIDTH  row r: C[r][z] at slice z*OUT_WIDTH, z=0..N-1.
- out_row  out  $clog2(N)  current row index r.
- out_last  out  1  high with out_valid on row N-1.
- clr_flags  in  1  clears sticky flags.
- sat_flag  out  1  sticky: any clamp or saturating add occurred.
- err_flag  out  1  sticky: in_valid seen while in_ready=0.

Behaviour:
- Reset (synchronous, active-high; takes effect at the next clk edge, including mid-drain):
  - State=ACC; buffer cleared to 0; row counter 0.
  - in_ready=1; out_valid=0; out_last=0; out_row=0; out_data=0; sat_flag=0; err_flag=0.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DRAIN: in_ready=0, out_valid=1.
- ACC, on in_valid, for each element:
  - Sign-extend or clamp the 2*ACC_WIDTH value to the OUT_WIDTH signed range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - in_first=1: buf = clamped value.
  - in_first=0: buf = sat(buf + clamped value). Compute the sum at OUT_WIDTH+1 bits, then saturate to the OUT_WIDTH range.
  - Any clamp or saturation sets sat_flag.
- ACC, on in_valid & in_last: capture or accumulate as above, then go to DRAIN at the same edge.
  - out_valid=1 with row 0 on the following cycle (1-cycle latency from the in_valid edge).
  - in_first & in_last together is a single-tile matmul.
- DRAIN:
  - out_data = buffer row out_row; out_last = (out_row==N-1).
  - On out_valid & out_ready: out_row increments.
  - On the handshake with out_last: buffer cleared to 0, out_row=0, state returns to ACC. in_ready=1 on the next cycle.
  - With out_ready low: out_data, out_row and out_last are held stable, and out_valid stays high. No bubbles between rows when out_ready is held high: N beats in N cycles.
- in_valid while in_ready=0: tile ignored, buffer unchanged, err_flag set.
- clr_flags clears sat_flag and err_flag at the next edge. A set event in the same cycle wins: the flag remains 1.
- in_valid without in_first after a completed drain adds to the zeroed buffer, which is equivalent to in_first.
- Buffer storage is registers (N*N*OUT_WIDTH bits). No combinational path from in_* to out_*.

Test Plan:
- Single tile, all elements 5, in_first=in_last=1, out_ready=1:
  - out_valid rises 1 cycle later; 8 consecutive beats, rows 0..7, every element 5.
  - out_last only on row 7; in_ready back to 1 the cycle after.
- Two tiles:
  - Tile of 3s (in_first) then tile of 4s (in_last) → all elements 7.
  - Distinct per-element pattern C[x][z]=16x+z → row r element z equals 2*(16r+z).
- Saturation:
  - Elements 2^31-1 twice → outputs 2147483647, sat_flag=1.
  - Element -2^35 single tile → output -2147483648, sat_flag=1.
  - clr_flags → sat_flag=0.
- Backpressure: out_ready low for 3 cycles at row 2 → out_data/out_row held at row 2, out_valid high; resumes with row 3, total beats still 8.
- Protocol error: in_valid pulse during DRAIN row 4 → err_flag=1, drained values unchanged from pre-pulse buffer.
- Reset mid-drain: rst at row 4 → next cycle out_valid=0, in_ready=1. A following single tile of 1s drains all 1s (no residue).
